// File: rtl/des_keysched_seq.sv
// Sequential DES key scheduler.
// Loads one 64-bit key through PC-1, then emits the 16 round keys (PC-2 of the rotated
// C/D halves) one per rk_valid_o/rk_ready_i transfer, in encrypt (K1..K16) or
// decrypt (K16..K1) order.
module des_keysched_seq #(
  parameter logic [15:0] SHIFT_SCHED = 16'h8103,
  parameter bit          OUT_REG     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  output logic [47:0] rk_o,
  output logic [3:0]  rk_round_o,
  output logic        rk_last_o,
  output logic        rk_valid_o,
  input  logic        rk_ready_i,
  output logic        busy_o
);

  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [27:0] c, d, nextC, nextD;
  logic [3:0]  cnt, rkRound, nextRound;
  logic        mode, rkValid, rkLast, loadCD;
  logic        accept, xfer;
  logic [55:0] pc1Key, pc2In;
  logic [47:0] pc2Out;
  logic        unusedBits;

  // true when round r rotates by a single bit
  function automatic logic oneBit(input logic [3:0] r);
    return SHIFT_SCHED[r];
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // parity bits of the key and the eight C/D bits PC-2 drops are deliberately unused
  assign unusedBits = ^{key_i[56], key_i[48], key_i[40], key_i[32], key_i[24], key_i[16],
                        key_i[8], key_i[0], pc2In[47], pc2In[38], pc2In[34], pc2In[31],
                        pc2In[21], pc2In[18], pc2In[13], pc2In[2]};

  assign accept      = key_valid_i && (state == IDLE);
  assign xfer        = rkValid && rk_ready_i;
  assign key_ready_o = (state == IDLE);
  assign busy_o      = (state == RUN);
  assign rk_valid_o  = rkValid;
  assign rk_round_o  = rkRound;
  assign rk_last_o   = rkLast;

  // PC-1: DES bit n of the key is key_i[64-n]
  always_comb begin
    pc1Key = '0;
    for (int unsigned i = 0; i < 56; i++) pc1Key[55 - i] = key_i[64 - PC1_TAB[i]];
  end

  // Next C/D and round index. C/D always hold the halves of the key currently on
  // rk_o: encrypt pre-applies the rotation for the upcoming round, decrypt applies
  // the inverse rotation after the key has been handed over.
  always_comb begin
    nextC     = c;
    nextD     = d;
    nextRound = rkRound;
    loadCD    = 1'b0;
    if (accept) begin
      loadCD = 1'b1;
      if (decrypt_i) begin
        nextC     = pc1Key[55:28];
        nextD     = pc1Key[27:0];
        nextRound = 4'd15;
      end else begin
        nextC     = rotl(pc1Key[55:28], oneBit(4'd0));
        nextD     = rotl(pc1Key[27:0], oneBit(4'd0));
        nextRound = 4'd0;
      end
    end else if (xfer && !rkLast) begin
      loadCD = 1'b1;
      if (mode) begin
        nextC     = rotr(c, oneBit(rkRound));
        nextD     = rotr(d, oneBit(rkRound));
        nextRound = rkRound - 4'd1;
      end else begin
        nextC     = rotl(c, oneBit(rkRound + 4'd1));
        nextD     = rotl(d, oneBit(rkRound + 4'd1));
        nextRound = rkRound + 4'd1;
      end
    end
  end

  // PC-2 source: next halves when rk_o is registered, current halves otherwise
  assign pc2In = OUT_REG ? {nextC, nextD} : {c, d};

  // PC-2: DES bit n of {C,D} is pc2In[56-n]
  always_comb begin
    pc2Out = '0;
    for (int unsigned i = 0; i < 48; i++) pc2Out[47 - i] = pc2In[56 - PC2_TAB[i]];
  end

  // schedule FSM, C/D halves, step counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      c       <= '0;
      d       <= '0;
      cnt     <= '0;
      mode    <= 1'b0;
      rkValid <= 1'b0;
      rkRound <= '0;
      rkLast  <= 1'b0;
    end else begin
      if (loadCD) begin
        c <= nextC;
        d <= nextD;
      end
      case (state)
        IDLE: if (accept) begin
          state   <= RUN;
          mode    <= decrypt_i;
          cnt     <= '0;
          rkValid <= 1'b1;
          rkRound <= nextRound;
          rkLast  <= 1'b0;
        end
        RUN: if (xfer) begin
          if (rkLast) begin
            state   <= IDLE;
            rkValid <= 1'b0;
            rkLast  <= 1'b0;
          end else begin
            cnt     <= cnt + 4'd1;
            rkRound <= nextRound;
            rkLast  <= (cnt == 4'd14);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (OUT_REG) begin : gRegOut
      logic [47:0] rkReg;
      // round key register, loaded together with C/D so it never lags the halves
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rkReg <= '0;
        else if (loadCD) rkReg <= pc2Out;
      end
      assign rk_o = rkReg;
    end else begin : gCombOut
      assign rk_o = pc2Out;
    end
  endgenerate

endmodule

// File: tb/tb_des_keysched_seq.sv
// Scoreboard bench for des_keysched_seq: a registered-output and a combinational-output
// instance run in lockstep against hand-computed round keys of 64'h133457799BBCDFF1.
module tb_des_keysched_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key_i = '0;
  logic        decrypt_i = 1'b0;
  logic        key_valid_i = 1'b0;
  logic        rk_ready_i = 1'b1;

  logic        keyReady, rkLast, rkValid, busy;
  logic [47:0] rk;
  logic [3:0]  rkRound;
  logic        keyReadyC, rkLastC, rkValidC, busyC;
  logic [47:0] rkC;
  logic [3:0]  rkRoundC;

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEYN = 64'hECCBA8866443200E;  // bitwise complement: keys complement
  localparam logic [63:0] KEYP = 64'h123556789ABDDEF0;  // parity bits flipped: same keys
  localparam logic [47:0] KTAB [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  typedef struct packed {
    logic [47:0] rk;
    logic [3:0]  round;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   xferEdges[$];
  int   acceptEdges[$];
  int   cycle = 0;
  int   nChecks = 0;
  int   nPass = 0;

  des_keysched_seq #(.SHIFT_SCHED(16'h8103), .OUT_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key_i(key_i), .decrypt_i(decrypt_i),
    .key_valid_i(key_valid_i), .key_ready_o(keyReady), .rk_o(rk), .rk_round_o(rkRound),
    .rk_last_o(rkLast), .rk_valid_o(rkValid), .rk_ready_i(rk_ready_i), .busy_o(busy));

  des_keysched_seq #(.SHIFT_SCHED(16'h8103), .OUT_REG(1'b0)) dutComb (
    .clk(clk), .rst_n(rst_n), .key_i(key_i), .decrypt_i(decrypt_i),
    .key_valid_i(key_valid_i), .key_ready_o(keyReadyC), .rk_o(rkC), .rk_round_o(rkRoundC),
    .rk_last_o(rkLastC), .rk_valid_o(rkValidC), .rk_ready_i(rk_ready_i), .busy_o(busyC));

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    nChecks++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic pushSched(input logic [47:0] mask, input bit dec);
    exp_t e;
    for (int j = 0; j < 16; j++) begin
      int r = dec ? 15 - j : j;
      e.rk    = KTAB[r] ^ mask;
      e.round = 4'(r);
      e.last  = (j == 15);
      sb.push_back(e);
    end
  endtask

  task automatic sendKey(input logic [63:0] k, input bit dec);
    int n = 0;
    key_i = k; decrypt_i = dec; key_valid_i = 1'b1;
    while (!keyReady && n < 100) begin @(posedge clk); #1; n++; end
    if (!keyReady) fail("key accept");
    @(posedge clk); #1;
    key_valid_i = 1'b0; key_i = ~k; decrypt_i = ~dec;
  endtask

  task automatic waitDrain(input int bound, input bit stall);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      rk_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    rk_ready_i = 1'b1;
    if (sb.size() != 0) fail("schedule drain");
  endtask

  function automatic int edgeAt(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1000;
  endfunction

  // monitor: whenever a key is presented it must be the scoreboard head; pop on transfer
  always @(negedge clk) begin
    if (rst_n && rkValid) begin
      if (sb.size() == 0) fail("unexpected rk_valid_o");
      else begin
        check("rk_o", rk, sb[0].rk);
        check("rk_o comb", rkC, sb[0].rk);
        check("rk_round_o", rkRound, sb[0].round);
        check("rk_round_o comb", rkRoundC, sb[0].round);
        check("rk_last_o", rkLast, sb[0].last);
        check("rk_last_o comb", rkLastC, sb[0].last);
        check("rk_valid_o comb", rkValidC, 1'b1);
        if (rk_ready_i) begin
          void'(sb.pop_front());
          xferEdges.push_back(cycle + 1);
        end
      end
    end
  end

  // acceptance tracker
  always @(negedge clk) begin
    if (rst_n && key_valid_i && keyReady) acceptEdges.push_back(cycle + 1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset rk_valid_o", rkValid, 1'b0);
    check("reset busy_o", busy, 1'b0);
    check("reset rk_o", rk, 48'h0);
    check("reset rk_o comb", rkC, 48'h0);
    check("reset rk_round_o", rkRound, 4'h0);
    check("reset rk_last_o", rkLast, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("key_ready_o after reset", keyReady, 1'b1);
    check("key_ready_o comb after reset", keyReadyC, 1'b1);

    // encrypt, no backpressure
    xferEdges.delete(); acceptEdges.delete();
    pushSched('0, 1'b0);
    sendKey(KEY, 1'b0);
    waitDrain(200, 1'b0);
    check("enc key count", xferEdges.size(), 16);
    check("enc first key latency", edgeAt(xferEdges, 0), edgeAt(acceptEdges, 0) + 1);
    check("enc 16 in 16 cycles", edgeAt(xferEdges, 15), edgeAt(acceptEdges, 0) + 16);
    @(negedge clk);
    check("valid low after last", rkValid, 1'b0);
    check("valid comb low after last", rkValidC, 1'b0);
    check("key_ready_o after last", keyReady, 1'b1);
    check("busy_o after last", busy, 1'b0);

    // decrypt, no backpressure
    xferEdges.delete(); acceptEdges.delete();
    pushSched('0, 1'b1);
    sendKey(KEY, 1'b1);
    waitDrain(200, 1'b0);
    check("dec key count", xferEdges.size(), 16);
    check("dec 16 in 16 cycles", edgeAt(xferEdges, 15), edgeAt(acceptEdges, 0) + 16);

    // random stalls on complemented key
    xferEdges.delete(); acceptEdges.delete();
    pushSched('1, 1'b0);
    sendKey(KEYN, 1'b0);
    waitDrain(400, 1'b1);
    check("stall key count", xferEdges.size(), 16);

    // key pulse while busy is ignored, then accepted once idle
    xferEdges.delete(); acceptEdges.delete();
    pushSched('0, 1'b0);
    sendKey(KEY, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    key_i = KEYN; decrypt_i = 1'b1; key_valid_i = 1'b1;
    @(negedge clk);
    check("key_ready_o while busy", keyReady, 1'b0);
    check("busy_o while running", busy, 1'b1);
    @(posedge clk); #1;
    key_valid_i = 1'b0;
    waitDrain(200, 1'b0);
    check("busy pulse not accepted", acceptEdges.size(), 1);
    pushSched('1, 1'b1);
    sendKey(KEYN, 1'b1);
    waitDrain(200, 1'b0);
    check("key accepted after idle", acceptEdges.size(), 2);

    // asynchronous reset mid-schedule
    xferEdges.delete(); acceptEdges.delete();
    pushSched('0, 1'b0);
    sendKey(KEY, 1'b0);
    n = 0;
    while (xferEdges.size() < 7 && n < 100) begin @(posedge clk); #1; n++; end
    if (xferEdges.size() < 7) fail("reach step 7");
    #2 rst_n = 1'b0;
    #1;
    check("async rst rk_valid_o", rkValid, 1'b0);
    check("async rst busy_o", busy, 1'b0);
    check("async rst rk_o", rk, 48'h0);
    check("async rst rk_o comb", rkC, 48'h0);
    check("async rst rk_round_o", rkRound, 4'h0);
    check("async rst rk_last_o", rkLast, 1'b0);
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("key_ready_o after release", keyReady, 1'b1);
    check("no partial key after release", rkValid, 1'b0);
    xferEdges.delete(); acceptEdges.delete();
    pushSched('0, 1'b0);
    sendKey(KEYP, 1'b0);
    waitDrain(200, 1'b0);
    check("fresh schedule count", xferEdges.size(), 16);

    // back-to-back keys with key_valid_i held
    xferEdges.delete(); acceptEdges.delete();
    pushSched('0, 1'b0);
    pushSched('1, 1'b1);
    key_i = KEY; decrypt_i = 1'b0; key_valid_i = 1'b1;
    n = 0;
    while (acceptEdges.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
    key_i = KEYN; decrypt_i = 1'b1;
    n = 0;
    while (acceptEdges.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    key_valid_i = 1'b0;
    if (acceptEdges.size() < 2) fail("second key accept");
    waitDrain(200, 1'b0);
    check("b2b key count", xferEdges.size(), 32);
    check("b2b acceptance spacing", edgeAt(acceptEdges, 1) - edgeAt(acceptEdges, 0), 17);
    check("b2b accept after last", edgeAt(acceptEdges, 1), edgeAt(xferEdges, 15) + 1);
    check("b2b second K1 latency", edgeAt(xferEdges, 16), edgeAt(acceptEdges, 1) + 1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
